// File: rtl/tdc_sched_pkg.sv
// Shared definitions for the TDC readout scheduler: state encoding, default
// register map of the TDC host interface, and the channel address helper.
package tdc_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_STAT = 3'd1,
    ST_PICK    = 3'd2,
    ST_RD_HI   = 3'd3,
    ST_RD_LO   = 3'd4,
    ST_WR_CLR  = 3'd5,
    ST_PUSH    = 3'd6
  } state_t;

  localparam logic [31:0] TDC_BASE_DEF   = 32'ha000_0000;
  localparam logic [7:0]  STAT_OFS_DEF   = 8'h00;
  localparam logic [7:0]  CLR_OFS_DEF    = 8'h04;
  localparam logic [7:0]  CH_OFS_DEF     = 8'h10;
  localparam logic [7:0]  CH_STRIDE_DEF  = 8'h08;
  localparam logic [2:0]  WB_CTI_CLASSIC = 3'b000;
  localparam logic [3:0]  WB_SEL_ALL     = 4'hf;

  // Address of channel ch's timestamp-hi word; the lo word sits 4 bytes above.
  function automatic logic [31:0] ch_hi_addr(input logic [31:0] base,
                                             input logic [7:0]  ofs,
                                             input logic [7:0]  stride,
                                             input logic [2:0]  ch);
    return base + 32'(ofs) + (32'(ch) * 32'(stride));
  endfunction

endpackage

// File: rtl/tdc_rr_pick.sv
// Round-robin first-set finder: the first set mask bit at or after rr,
// wrapping from NCHAN-1 back to 0.
module tdc_rr_pick #(
  parameter int NCHAN = 2
) (
  input  logic [NCHAN-1:0] mask,
  input  logic [2:0]       rr,
  output logic             valid,
  output logic [2:0]       idx
);

  logic [7:0] mask8;
  logic [3:0] cand;

  assign mask8 = 8'(mask);

  always_comb begin
    valid = 1'b0;
    idx   = 3'd0;
    cand  = 4'd0;
    for (int k = 0; k < NCHAN; k++) begin
      cand = {1'b0, rr} + 4'(k);
      if (cand >= 4'(NCHAN)) cand = cand - 4'(NCHAN);
      if (!valid && mask8[cand[2:0]]) begin
        valid = 1'b1;
        idx   = cand[2:0];
      end
    end
  end

endmodule

// File: rtl/tdc_readout_sched.sv
// Autonomous Wishbone master draining TDC timestamps: scan the pending mask,
// pick a channel round-robin, read hi/lo, clear it, and hand the event downstream.
module tdc_readout_sched
  import tdc_sched_pkg::*;
#(
  parameter int          NCHAN     = 2,
  parameter logic [31:0] TDC_BASE  = TDC_BASE_DEF,
  parameter logic [7:0]  STAT_OFS  = STAT_OFS_DEF,
  parameter logic [7:0]  CLR_OFS   = CLR_OFS_DEF,
  parameter logic [7:0]  CH_OFS    = CH_OFS_DEF,
  parameter logic [7:0]  CH_STRIDE = CH_STRIDE_DEF,
  parameter int          POLL_W    = 16,
  parameter int          TMO       = 255
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              enable,
  input  logic [POLL_W-1:0] poll_div,
  input  logic              tdc_irq,
  output logic [31:0]       wb_adr_o,
  output logic [31:0]       wb_dat_o,
  input  logic [31:0]       wb_dat_i,
  output logic [3:0]        wb_sel_o,
  output logic              wb_we_o,
  output logic [2:0]        wb_cti_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  input  logic              wb_ack_i,
  output logic              ev_stb,
  input  logic              ev_ack,
  output logic [2:0]        ev_chan,
  output logic [63:0]       ev_ts,
  output logic [15:0]       ev_lost,
  output logic              busy,
  output logic [2:0]        state_dbg
);

  // Event handshake: an event transfers on a clock edge where ev_stb and ev_ack
  // are both high; ev_stb, ev_chan and ev_ts hold steady until then, and ev_ack
  // with ev_stb low has no effect.

  state_t            state;
  logic [NCHAN-1:0]  mask_q;
  logic [2:0]        rr;
  logic [2:0]        chan_q;
  logic [31:0]       hi_q;
  logic [31:0]       lo_q;
  logic [POLL_W-1:0] poll_cnt;
  logic [7:0]        tmo_cnt;
  logic              pick_valid;
  logic [2:0]        pick_idx;
  logic              poll_on;
  logic              poll_exp;
  logic [31:0]       req_adr;
  logic [31:0]       req_dat;
  logic              req_we;

  tdc_rr_pick #(.NCHAN(NCHAN)) u_pick (
    .mask  (mask_q),
    .rr    (rr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign poll_on  = enable && (poll_div != '0);
  assign poll_exp = poll_on && (poll_cnt == poll_div - POLL_W'(1));

  // Access presented by the bus state currently waiting to start its cycle.
  always_comb begin
    req_adr = TDC_BASE + 32'(STAT_OFS);
    req_we  = 1'b0;
    req_dat = 32'd0;
    case (state)
      ST_RD_HI: req_adr = ch_hi_addr(TDC_BASE, CH_OFS, CH_STRIDE, chan_q);
      ST_RD_LO: req_adr = ch_hi_addr(TDC_BASE, CH_OFS, CH_STRIDE, chan_q) + 32'd4;
      ST_WR_CLR: begin
        req_adr = TDC_BASE + 32'(CLR_OFS);
        req_we  = 1'b1;
        req_dat = 32'd1 << chan_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state    <= ST_IDLE;
      wb_adr_o <= 32'd0;
      wb_dat_o <= 32'd0;
      wb_we_o  <= 1'b0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      ev_stb   <= 1'b0;
      ev_lost  <= 16'd0;
      mask_q   <= '0;
      rr       <= 3'd0;
      chan_q   <= 3'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      poll_cnt <= '0;
      tmo_cnt  <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (poll_on) poll_cnt <= poll_exp ? '0 : poll_cnt + POLL_W'(1);
          if (enable && (tdc_irq || poll_exp)) state <= ST_RD_STAT;
        end
        ST_PICK: begin
          if (!pick_valid || !enable) begin
            state <= ST_IDLE;
          end else begin
            chan_q <= pick_idx;
            rr     <= (pick_idx == 3'(NCHAN - 1)) ? 3'd0 : pick_idx + 3'd1;
            state  <= ST_RD_HI;
          end
        end
        ST_PUSH: begin
          if (ev_ack) begin
            ev_stb <= 1'b0;
            state  <= enable ? ST_RD_STAT : ST_IDLE;
          end
        end
        ST_RD_STAT, ST_RD_HI, ST_RD_LO, ST_WR_CLR: begin
          // Cycle starts the edge after state entry, so cyc is always low for
          // at least one cycle between accesses.
          if (!wb_cyc_o) begin
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_adr_o <= req_adr;
            wb_we_o  <= req_we;
            wb_dat_o <= req_dat;
            tmo_cnt  <= 8'd0;
          end else if (wb_ack_i) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            case (state)
              ST_RD_STAT: begin
                mask_q <= wb_dat_i[NCHAN-1:0];
                state  <= ST_PICK;
              end
              ST_RD_HI: begin
                hi_q  <= wb_dat_i;
                state <= ST_RD_LO;
              end
              ST_RD_LO: begin
                lo_q  <= wb_dat_i;
                state <= ST_WR_CLR;
              end
              default: begin
                ev_stb <= 1'b1;
                state  <= ST_PUSH;
              end
            endcase
          end else if (tmo_cnt == 8'(TMO - 1)) begin
            // Abandon without clearing so the channel is picked up again later.
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            if (ev_lost != 16'hffff) ev_lost <= ev_lost + 16'd1;
            state    <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ev_chan   = chan_q;
  assign ev_ts     = {hi_q, lo_q};
  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;
  assign wb_sel_o  = WB_SEL_ALL;
  assign wb_cti_o  = WB_CTI_CLASSIC;

endmodule
